instr_prefetch: RTL and testbench
=================================

// Module: instr_prefetch
//
// PURPOSE
// - Fetch stage directly upstream of the instruction register (ir).
// - Runs the sequential fetch address and issues one-at-a-time word requests to instruction memory.
// - Buffers returned words in a DEPTH-entry FIFO.
// - Presents the head word on read_data and asserts ir_load so the ir captures it.
// - A redirect (branch/jump) flushes the queue and restarts fetch at a new address.
//
// PARAMETERS
// - DEPTH   4   prefetch FIFO entries; power of two, >= 2
// - ADDR_W  16  instruction word address width
// - DATA_W  32  instruction width; matches ir read_data
//
// PORTS
// - clk            in   1       system clock, posedge active
// - rst            in   1       synchronous reset, active-high
// - redirect       in   1       1 = discard all fetched/in-flight words, restart at redirect_addr
// - redirect_addr  in   ADDR_W  new fetch address, sampled when redirect=1
// - stall          in   1       1 = downstream cannot accept an instruction this cycle
// - imem_req       out  1       memory read request; held until imem_ack
// - imem_addr      out  ADDR_W  word address of the request; stable while imem_req=1
// - imem_ack       in   1       memory returns imem_rdata this cycle; ignored while imem_req=0
// - imem_rdata     in   DATA_W  returned instruction word, valid with imem_ack
// - ir_load        out  1       head word valid and consumed this cycle; drives ir.ir_load
// - read_data      out  DATA_W  FIFO head word; drives ir.read_data
// - fetch_pc       out  ADDR_W  address of the word on read_data
//
// BEHAVIOUR
// Reset (rst=1 at posedge)
// - FIFO empty; count=0; fetch address=0.
// - FSM goes to IDLE; imem_req=0; ir_load=0; read_data=0; fetch_pc=0.
//
// FSM states
// - IDLE: if (count + 0) < DEPTH and !redirect, assert imem_req with imem_addr = fetch address next cycle, then go to WAIT.
// - WAIT: imem_req=1.
//   - On imem_ack with no redirect: push {imem_rdata, imem_addr}, increment the fetch address, go to IDLE.
//   - On redirect: go to DISCARD.
// - DISCARD: imem_req stays 1 because the in-flight request cannot be aborted.
//   - On imem_ack, drop the data and go to IDLE.
//   - The fetch address already equals the latched redirect_addr.
//
// Issue and fill
// - Request issue is limited so count + outstanding <= DEPTH; a push therefore never overflows.
// - Back-to-back fetch: one request per 2 cycles minimum (IDLE->WAIT, ack in WAIT).
// - Zero-wait memory: ack may arrive in the first WAIT cycle.
//
// Output handshake
// - ir_load = (count != 0) & !stall & !redirect, combinational.
// - The head is popped at the same posedge the ir captures it.
// - read_data and fetch_pc always show the head entry; they hold their last value when empty.
//
// Boundary conditions
// - Push and pop in the same cycle: count unchanged; order preserved.
// - Empty: ir_load=0 regardless of stall.
// - Full: IDLE does not issue; imem_req=0 until a pop frees an entry.
// - Redirect on any cycle:
//   - FIFO flushed (count=0) at that posedge; fetch address <= redirect_addr.
//   - ir_load forced 0 in that cycle.
//   - Redirect in WAIT goes to DISCARD; redirect in DISCARD re-latches redirect_addr.
// - Redirect and imem_ack in the same cycle: returned word dropped; FSM goes to IDLE.
// - Fetch address increment wraps from 2^ADDR_W-1 to 0.
// - Reset mid-request: imem_req drops next cycle; a late imem_ack is ignored because imem_req=0.
//
// CONFIGURATION
// - PREFETCH_PERF_EN defined:
//   - Adds outputs flush_count[15:0] and starve_count[15:0], both reset to 0.
//   - flush_count increments on each redirect.
//   - starve_count increments each cycle with count==0 and stall=0.
//   - Both counters saturate at 16'hFFFF.
// - PREFETCH_PERF_EN undefined: these ports and their logic are absent.
//
// TESTING
// - Reset, zero-wait memory returning word=addr, stall=0:
//   - ir_load pulses with read_data 0,1,2,3...
//   - fetch_pc equals read_data.
//   - First ir_load arrives by cycle 3 after reset release.
// - Fill, then stall=1 for 10 cycles:
//   - count reaches 4; imem_req=0 while full; no ir_load.
//   - On release, 4 consecutive ir_load cycles deliver words in order.
// - Redirect to 0x0100 while in WAIT with a 3-cycle memory:
//   - Old ack data is dropped.
//   - The next delivered word has fetch_pc=0x0100.
//   - No pre-redirect word appears after the redirect.
// - Redirect and imem_ack in the same cycle:
//   - The acked word never reaches read_data.
//   - count=0 the next cycle.
// - Fetch from 0xFFFE with ADDR_W=16: fetch_pc sequence FFFE, FFFF, 0000, 0001.
// - Assert rst while a request is outstanding, then ack 2 cycles later:
//   - imem_req=0 after reset; the ack is ignored.
//   - Fetch restarts at 0x0000.
//   - With PREFETCH_PERF_EN: counters read 0.

Source files
------------

// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential instruction fetch feeding the ir through a DEPTH-entry prefetch FIFO.
// Define PREFETCH_PERF_EN to add saturating flush_count / starve_count outputs.
module instr_prefetch #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ir_load,
    output logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] fetch_pc
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0]       flush_count,
    output logic [15:0]       starve_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t            state;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] last_data;
    logic [ADDR_W-1:0] last_pc;
    logic              not_empty;
    logic              push;

    assign not_empty = (count != '0);
    assign push      = (state == WAIT) && imem_ack && !redirect;
    assign ir_load   = not_empty && !stall && !redirect;
    assign read_data = not_empty ? data_mem[rd_ptr] : last_data;
    assign fetch_pc  = not_empty ? pc_mem[rd_ptr]   : last_pc;

    // NOTE: FIFO storage is not reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= imem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            fetch_addr <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_data  <= '0;
            last_pc    <= '0;
        end else begin
            // Remember the head so the outputs hold it once the FIFO drains or is flushed.
            if (not_empty) begin
                last_data <= data_mem[rd_ptr];
                last_pc   <= pc_mem[rd_ptr];
            end

            if (redirect) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                fetch_addr <= redirect_addr;
            end else begin
                if (push) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    fetch_addr <= fetch_addr + 1'b1;
                end
                if (ir_load) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                unique case ({push, ir_load})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end

            unique case (state)
                IDLE: begin
                    // Only one request is ever outstanding, so count < DEPTH guarantees room for it.
                    if (count < FULL && !redirect) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_addr;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end else if (redirect) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef PREFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_count  <= '0;
            starve_count <= '0;
        end else begin
            if (redirect && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'd1;
            end
            if (!not_empty && !stall && starve_count != 16'hFFFF) begin
                starve_count <= starve_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: randomized-latency memory plus a queue-based reference model of the delivered word stream.
module tb_instr_prefetch;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              stall;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              ir_load;
    logic [DATA_W-1:0] read_data;
    logic [ADDR_W-1:0] fetch_pc;
`ifdef PREFETCH_PERF_EN
    logic [15:0]       flush_count;
    logic [15:0]       starve_count;
`endif

    always #5 clk = ~clk;

    instr_prefetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ir_load       (ir_load),
        .read_data     (read_data),
        .fetch_pc      (fetch_pc)
`ifdef PREFETCH_PERF_EN
        ,
        .flush_count   (flush_count),
        .starve_count  (starve_count)
`endif
    );

    typedef struct {
        logic [15:0] pc;
        logic [31:0] data;
    } entry_t;

    int checks = 0;
    int errors = 0;

    // Reference model: the words the ir should still receive, in order, plus the next fetch address.
    entry_t      q[$];
    entry_t      last_e;
    logic [15:0] next_fetch;
    bit          model_valid = 0;
    bit          prev_valid = 0, prev_req = 0, prev_rst = 0, prev_redirect = 0;
    int          prev_size = 0;

    // Memory model state.
    bit          busy = 0, stale = 0, ack_prev = 0, inject = 0, new_req = 0;
    int          cnt = 0, lat = 0, lat_min = 0, lat_max = 0;
    logic [15:0] req_addr = '0;
    logic [15:0] salt = '0;

    // Values sampled mid-cycle, for scenario checks.
    logic        s_ir_load, s_imem_req, s_ack;
    logic [31:0] s_read_data, s_rdata;
    logic [15:0] s_fetch_pc;

    function automatic logic [31:0] word(input logic [15:0] a);
        return {salt, a};
    endfunction

    task automatic cycle(input bit r, input bit s, input bit rd, input logic [15:0] ra);
        bit     exp_load;
        bit     accept;
        entry_t e;
        @(negedge clk);
        rst = r; stall = s; redirect = rd; redirect_addr = ra;
        if (ack_prev || imem_req !== 1'b1) busy = 0;
        imem_ack = 1'b0;
        new_req  = 0;
        if (imem_req === 1'b1) begin
            if (!busy) begin
                busy = 1; cnt = 0; stale = 0; new_req = 1;
                lat = $urandom_range(lat_max, lat_min);
                req_addr = imem_addr;
            end
            imem_ack   = (cnt == lat);
            imem_rdata = word(req_addr);
            cnt++;
        end else if (inject) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end
        ack_prev = imem_ack && (imem_req === 1'b1);
        #1;
        s_ir_load = ir_load; s_imem_req = imem_req; s_ack = imem_ack;
        s_read_data = read_data; s_rdata = imem_rdata; s_fetch_pc = fetch_pc;
        exp_load = (q.size() != 0) && !s && !rd;

        if (model_valid) begin
            checks++;
            if (ir_load !== exp_load) begin
                errors++;
                $display("FAIL ir_load t=%0t got=%b exp=%b", $time, ir_load, exp_load);
            end
            checks++;
            if (q.size() != 0) begin
                if (read_data !== q[0].data || fetch_pc !== q[0].pc) begin
                    errors++;
                    $display("FAIL head t=%0t got=%h/%h exp=%h/%h", $time, fetch_pc, read_data, q[0].pc, q[0].data);
                end
            end else if (read_data !== last_e.data || fetch_pc !== last_e.pc) begin
                errors++;
                $display("FAIL hold t=%0t got=%h/%h exp=%h/%h", $time, fetch_pc, read_data, last_e.pc, last_e.data);
            end
            checks++;
            if (imem_req === 1'b1 && !stale && q.size() >= DEPTH) begin
                errors++;
                $display("FAIL overissue t=%0t got req=1 with %0d queued, exp req=0", $time, q.size());
            end
            if (new_req) begin
                checks++;
                if (imem_addr !== next_fetch) begin
                    errors++;
                    $display("FAIL req_addr t=%0t got=%h exp=%h", $time, imem_addr, next_fetch);
                end
            end else if (busy) begin
                checks++;
                if (imem_addr !== req_addr) begin
                    errors++;
                    $display("FAIL addr_stable t=%0t got=%h exp=%h", $time, imem_addr, req_addr);
                end
            end
            if (prev_valid && prev_rst) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL req_after_rst t=%0t got=%b exp=0", $time, imem_req);
                end
            end else if (prev_valid && !prev_req && !prev_redirect && prev_size < DEPTH) begin
                checks++;
                if (imem_req !== 1'b1) begin
                    errors++;
                    $display("FAIL issue t=%0t got req=%b exp=1", $time, imem_req);
                end
            end
        end

        prev_valid = model_valid; prev_req = (imem_req === 1'b1);
        prev_rst = r; prev_redirect = rd; prev_size = q.size();
        if (r) begin
            q.delete();
            next_fetch = '0;
            last_e.pc = '0; last_e.data = '0;
            stale = 1;
            model_valid = 1;
        end else if (model_valid) begin
            if (q.size() != 0) last_e = q[0];
            accept = imem_ack && (imem_req === 1'b1) && !stale && !rd;
            if (rd) begin
                if (imem_req === 1'b1) stale = 1;
                q.delete();
                next_fetch = ra;
            end else begin
                if (exp_load) void'(q.pop_front());
                if (accept) begin
                    e.pc = req_addr; e.data = imem_rdata;
                    q.push_back(e);
                    next_fetch = next_fetch + 16'd1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic wait_fresh_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, '0);
            #1;
            if (!s_imem_req && imem_req === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        lat_min = 0; lat_max = 0; salt = '0; inject = 0;
        repeat (3) cycle(1, 0, 0, '0);
        #1;
        checks++;
        if (imem_req !== 1'b0 || ir_load !== 1'b0 || read_data !== '0 || fetch_pc !== '0) begin
            errors++;
            $display("FAIL reset_state got req=%b load=%b data=%h pc=%h exp all 0", imem_req, ir_load, read_data, fetch_pc);
        end
`ifdef PREFETCH_PERF_EN
        checks++;
        if (flush_count !== 16'd0 || starve_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf got=%h/%h exp=0/0", flush_count, starve_count);
        end
`endif
    endtask

    task automatic test_zero_wait;
        int first = -1;
        int n = 0;
        for (int c = 1; c <= 20; c++) begin
            cycle(0, 0, 0, '0);
            if (s_ir_load) begin
                if (first < 0) first = c;
                checks++;
                if (s_read_data !== 32'(n) || s_fetch_pc !== 16'(n)) begin
                    errors++;
                    $display("FAIL zero_wait_seq got=%h/%h exp=%h", s_fetch_pc, s_read_data, n);
                end
                n++;
            end
        end
        checks++;
        if (first < 0 || first > 3) begin
            errors++;
            $display("FAIL first_load got cycle=%0d exp<=3", first);
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL zero_wait_rate got=%0d loads exp=9", n);
        end
    endtask

    task automatic test_stall_fill;
        logic [15:0] first_pc;
        for (int c = 1; c <= 10; c++) begin
            cycle(0, 1, 0, '0);
            checks++;
            if (s_ir_load !== 1'b0) begin
                errors++;
                $display("FAIL stall_load cycle=%0d got=1 exp=0", c);
            end
            if (c >= 9) begin
                checks++;
                if (s_imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL full_req cycle=%0d got=%b exp=0", c, s_imem_req);
                end
            end
        end
        first_pc = '0;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, '0);
            if (k == 0) first_pc = s_fetch_pc;
            checks++;
            if (s_ir_load !== 1'b1 || s_fetch_pc !== 16'(16'd9 + k)) begin
                errors++;
                $display("FAIL drain k=%0d got load=%b pc=%h exp load=1 pc=%h", k, s_ir_load, s_fetch_pc, 16'(16'd9 + k));
            end
        end
        checks++;
        if (first_pc !== 16'd9) begin
            errors++;
            $display("FAIL drain_first got=%h exp=0009", first_pc);
        end
    endtask

    task automatic test_redirect_wait;
        bit ok;
        int k = 0;
        salt = 16'h1234; lat_min = 2; lat_max = 2;
        wait_fresh_req(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL redir_wait_setup got no request exp request");
        end
        cycle(0, 0, 1, 16'h0100);
        for (int c = 0; c < 40 && k < 4; c++) begin
            cycle(0, 0, 0, '0);
            if (s_ir_load) begin
                checks++;
                if (s_fetch_pc !== 16'(16'h0100 + k) || s_read_data !== word(16'(16'h0100 + k))) begin
                    errors++;
                    $display("FAIL redir_wait k=%0d got=%h/%h exp pc=%h", k, s_fetch_pc, s_read_data, 16'(16'h0100 + k));
                end
                k++;
            end
        end
        checks++;
        if (k < 4) begin
            errors++;
            $display("FAIL redir_wait_timeout got=%0d loads exp=4", k);
        end
    endtask

    task automatic test_redirect_ack;
        bit          ok;
        bit          seen = 0;
        logic [31:0] dropped;
        salt = 16'h5A5A; lat_min = 1; lat_max = 1;
        wait_fresh_req(ok);
        cycle(0, 0, 0, '0);
        cycle(0, 0, 1, 16'h0200);
        dropped = s_rdata;
        checks++;
        if (!ok || s_ack !== 1'b1) begin
            errors++;
            $display("FAIL redir_ack_setup got ack=%b exp=1", s_ack);
        end
        cycle(0, 0, 0, '0);
        checks++;
        if (s_ir_load !== 1'b0) begin
            errors++;
            $display("FAIL redir_ack_count got load=%b exp=0", s_ir_load);
        end
        for (int c = 0; c < 20; c++) begin
            cycle(0, 0, 0, '0);
            if (s_ir_load) begin
                checks++;
                if (s_read_data === dropped) begin
                    errors++;
                    $display("FAIL redir_ack_leak got=%h exp not %h", s_read_data, dropped);
                end
                if (!seen) begin
                    seen = 1;
                    checks++;
                    if (s_fetch_pc !== 16'h0200) begin
                        errors++;
                        $display("FAIL redir_ack_pc got=%h exp=0200", s_fetch_pc);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap;
        logic [15:0] exp_pc[4];
        int k = 0;
        exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
        lat_min = 0; lat_max = 0;
        cycle(0, 0, 1, 16'hFFFE);
        for (int c = 0; c < 30 && k < 4; c++) begin
            cycle(0, 0, 0, '0);
            if (s_ir_load) begin
                checks++;
                if (s_fetch_pc !== exp_pc[k]) begin
                    errors++;
                    $display("FAIL wrap k=%0d got=%h exp=%h", k, s_fetch_pc, exp_pc[k]);
                end
                k++;
            end
        end
        checks++;
        if (k < 4) begin
            errors++;
            $display("FAIL wrap_timeout got=%0d loads exp=4", k);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen = 0;
        lat_min = 5; lat_max = 5;
        wait_fresh_req(ok);
        cycle(0, 0, 0, '0);
        cycle(1, 0, 0, '0);
        #1;
        checks++;
        if (!ok || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_req got=%b exp=0", imem_req);
        end
`ifdef PREFETCH_PERF_EN
        checks++;
        if (flush_count !== 16'd0 || starve_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_perf got=%h/%h exp=0/0", flush_count, starve_count);
        end
`endif
        inject = 1;
        cycle(0, 0, 0, '0);
        inject = 0;
        checks++;
        if (s_ack !== 1'b1 || s_imem_req !== 1'b0 || s_ir_load !== 1'b0) begin
            errors++;
            $display("FAIL late_ack got ack=%b req=%b load=%b exp 1/0/0", s_ack, s_imem_req, s_ir_load);
        end
        lat_min = 0; lat_max = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cycle(0, 0, 0, '0);
            if (s_ir_load) begin
                seen = 1;
                checks++;
                if (s_fetch_pc !== 16'h0000 || s_read_data !== word(16'h0000)) begin
                    errors++;
                    $display("FAIL restart got=%h/%h exp=0000/%h", s_fetch_pc, s_read_data, word(16'h0000));
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL restart_timeout got no load exp load");
        end
    endtask

    task automatic test_random;
        int loads = 0;
        salt = 16'($urandom); lat_min = 0; lat_max = 3;
        for (int c = 0; c < 800; c++) begin
            cycle($urandom_range(99) == 0, $urandom_range(99) < 30,
                  $urandom_range(99) < 5, 16'($urandom));
            if (s_ir_load) loads++;
        end
        checks++;
        if (loads < 50) begin
            errors++;
            $display("FAIL random_progress got=%0d loads exp>=50", loads);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        test_reset();
        test_zero_wait();
        test_stall_fill();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
